// File: rtl/predecode_pkg.sv
// Shared types and constants for the RV32I issue-bundle predecoder.
// Optional dependency-matrix support lives behind PREDEC_DEP_EN in instr_predecode.
package predecode_pkg;

    localparam int unsigned ISSUEWIDTH = 4;
    localparam int unsigned DEPTH      = 2;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned SLOT_W     = 64;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned CLS_W      = 4;
    localparam int unsigned INSTR_LSB  = 0;
    localparam int unsigned PC_LSB     = 32;

    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [CLS_W-1:0] {
        CLS_ALU     = 4'd0,
        CLS_ALUI    = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_SYSTEM  = 4'd9,
        CLS_ILLEGAL = 4'd15
    } cls_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DROP = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        cls_t             cls;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
    } pd_slot_t;

    function automatic logic writes_rd(input cls_t c);
        return (c == CLS_ALU) || (c == CLS_ALUI) || (c == CLS_LOAD) || (c == CLS_JAL) ||
               (c == CLS_JALR) || (c == CLS_LUI) || (c == CLS_AUIPC);
    endfunction

    function automatic logic reads_rs1(input cls_t c);
        return (c == CLS_ALU) || (c == CLS_ALUI) || (c == CLS_LOAD) || (c == CLS_STORE) ||
               (c == CLS_BRANCH) || (c == CLS_JALR);
    endfunction

    function automatic logic reads_rs2(input cls_t c);
        return (c == CLS_ALU) || (c == CLS_STORE) || (c == CLS_BRANCH);
    endfunction

endpackage

// File: rtl/slot_predecode.sv
// Combinational RV32I predecoder for one {PC, instruction} slot.
module slot_predecode
    import predecode_pkg::*;
(
    input  logic [SLOT_W-1:0] entry,
    output pd_slot_t          slot
);

    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign ins   = entry[INSTR_LSB +: XLEN];
    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'h000};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    // Register fields are taken from fixed positions regardless of format.
    always_comb begin
        slot       = '0;
        slot.valid = (ins != NOP_WORD);
        slot.rd    = ins[11:7];
        slot.rs1   = ins[19:15];
        slot.rs2   = ins[24:20];
        slot.pc    = entry[PC_LSB +: XLEN];
        slot.cls   = CLS_ILLEGAL;
        slot.imm   = '0;
        case (ins[6:0])
            OP_ALU:    slot.cls = CLS_ALU;
            OP_ALUI:   begin slot.cls = CLS_ALUI;   slot.imm = imm_i; end
            OP_LOAD:   begin slot.cls = CLS_LOAD;   slot.imm = imm_i; end
            OP_STORE:  begin slot.cls = CLS_STORE;  slot.imm = imm_s; end
            OP_BRANCH: begin slot.cls = CLS_BRANCH; slot.imm = imm_b; end
            OP_JAL:    begin slot.cls = CLS_JAL;    slot.imm = imm_j; end
            OP_JALR:   begin slot.cls = CLS_JALR;   slot.imm = imm_i; end
            OP_LUI:    begin slot.cls = CLS_LUI;    slot.imm = imm_u; end
            OP_AUIPC:  begin slot.cls = CLS_AUIPC;  slot.imm = imm_u; end
            OP_SYSTEM: begin slot.cls = CLS_SYSTEM; slot.imm = imm_i; end
            default:   slot.cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/instr_predecode.sv
// Issue-bundle predecoder: per-slot RV32I decode, JAL early redirect, 2-entry bundle FIFO.
// Define PREDEC_DEP_EN to add the intra-bundle RAW dependency output o_dep.
module instr_predecode
    import predecode_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [ISSUEWIDTH*SLOT_W-1:0]  i_bundle,
    input  logic                          i_flush,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [ISSUEWIDTH-1:0]         o_slot_valid,
    output logic [ISSUEWIDTH*CLS_W-1:0]   o_class,
    output logic [ISSUEWIDTH*REG_W-1:0]   o_rd,
    output logic [ISSUEWIDTH*REG_W-1:0]   o_rs1,
    output logic [ISSUEWIDTH*REG_W-1:0]   o_rs2,
    output logic [ISSUEWIDTH*XLEN-1:0]    o_imm,
    output logic [ISSUEWIDTH*XLEN-1:0]    o_pc,
    output logic                          o_redirect,
    output logic [XLEN-1:0]               o_redirect_pc
`ifdef PREDEC_DEP_EN
    ,
    output logic [ISSUEWIDTH*ISSUEWIDTH-1:0] o_dep
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    pd_slot_t                  dec [ISSUEWIDTH];
    pd_slot_t [ISSUEWIDTH-1:0] enq_c;
    pd_slot_t [ISSUEWIDTH-1:0] fifo_q [DEPTH];
    logic [ISSUEWIDTH-1:0]     slot_v;
    logic                      jal_hit;
    logic [XLEN-1:0]           jal_tgt;
    logic [CNT_W-1:0]          count_q;
    logic [IDX_W-1:0]          wr_idx;
    logic                      accept_run;
    logic                      push;
    logic                      pop;
    logic                      redirect_d;
    state_t                    state_q;
    state_t                    state_d;

    for (genvar k = 0; k < ISSUEWIDTH; k++) begin : g_slot
        slot_predecode u_slot (
            .entry (i_bundle[k*SLOT_W +: SLOT_W]),
            .slot  (dec[k])
        );
    end

    // Lowest valid JAL wins; every younger slot is squashed.
    always_comb begin
        jal_hit = 1'b0;
        jal_tgt = '0;
        slot_v  = '0;
        enq_c   = '0;
        for (int k = 0; k < ISSUEWIDTH; k++) begin
            slot_v[k]      = dec[k].valid && !jal_hit;
            enq_c[k]       = dec[k];
            enq_c[k].valid = slot_v[k];
            if (slot_v[k] && (dec[k].cls == CLS_JAL)) begin
                jal_hit = 1'b1;
                jal_tgt = dec[k].pc + dec[k].imm;
            end
        end
    end

    assign o_ready    = (state_q == ST_DROP) || (count_q < CNT_W'(DEPTH));
    assign o_valid    = (count_q != '0);
    assign accept_run = i_valid && o_ready && !i_flush && (state_q == ST_RUN);
    assign push       = accept_run && (slot_v != '0);
    assign pop        = o_valid && i_ready;
    assign wr_idx     = IDX_W'(count_q - CNT_W'(pop));

    always_comb begin
        state_d    = state_q;
        redirect_d = 1'b0;
        if (i_flush) begin
            state_d = ST_RUN;
        end else if (accept_run && jal_hit) begin
            state_d    = ST_DROP;
            redirect_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            o_redirect    <= 1'b0;
            o_redirect_pc <= '0;
        end else begin
            state_q    <= state_d;
            o_redirect <= redirect_d;
            if (redirect_d) begin
                o_redirect_pc <= jal_tgt;
            end
        end
    end

    // Shift FIFO: entry 0 is always the head, unused entries are held at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < DEPTH; e++) fifo_q[e] <= '0;
            count_q <= '0;
        end else if (i_flush) begin
            for (int e = 0; e < DEPTH; e++) fifo_q[e] <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                for (int e = 0; e < DEPTH - 1; e++) fifo_q[e] <= fifo_q[e+1];
                fifo_q[DEPTH-1] <= '0;
            end
            if (push) begin
                fifo_q[wr_idx] <= enq_c;
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_comb begin
        o_slot_valid = '0;
        o_class      = '0;
        o_rd         = '0;
        o_rs1        = '0;
        o_rs2        = '0;
        o_imm        = '0;
        o_pc         = '0;
        for (int k = 0; k < ISSUEWIDTH; k++) begin
            o_slot_valid[k]           = fifo_q[0][k].valid;
            o_class[k*CLS_W +: CLS_W] = fifo_q[0][k].cls;
            o_rd[k*REG_W +: REG_W]    = fifo_q[0][k].rd;
            o_rs1[k*REG_W +: REG_W]   = fifo_q[0][k].rs1;
            o_rs2[k*REG_W +: REG_W]   = fifo_q[0][k].rs2;
            o_imm[k*XLEN +: XLEN]     = fifo_q[0][k].imm;
            o_pc[k*XLEN +: XLEN]      = fifo_q[0][k].pc;
        end
    end

`ifdef PREDEC_DEP_EN
    logic [ISSUEWIDTH*ISSUEWIDTH-1:0] dep_c;
    logic [ISSUEWIDTH*ISSUEWIDTH-1:0] dep_q [DEPTH];

    // Bit 4j+i: younger slot j reads a nonzero rd written by older slot i.
    always_comb begin
        dep_c = '0;
        for (int j = 1; j < ISSUEWIDTH; j++) begin
            for (int i = 0; i < j; i++) begin
                if (slot_v[j] && slot_v[i] && writes_rd(dec[i].cls) && (dec[i].rd != '0) &&
                    ((reads_rs1(dec[j].cls) && (dec[j].rs1 == dec[i].rd)) ||
                     (reads_rs2(dec[j].cls) && (dec[j].rs2 == dec[i].rd)))) begin
                    dep_c[j*ISSUEWIDTH + i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < DEPTH; e++) dep_q[e] <= '0;
        end else if (i_flush) begin
            for (int e = 0; e < DEPTH; e++) dep_q[e] <= '0;
        end else begin
            if (pop) begin
                for (int e = 0; e < DEPTH - 1; e++) dep_q[e] <= dep_q[e+1];
                dep_q[DEPTH-1] <= '0;
            end
            if (push) begin
                dep_q[wr_idx] <= dep_c;
            end
        end
    end

    assign o_dep = dep_q[0];
`endif

endmodule

// File: tb/tb_instr_predecode.sv
// Directed, table-driven bench for instr_predecode plus hand-written handshake/flush/drop sequences.
module tb_instr_predecode;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic [255:0] i_bundle;
    logic         i_flush;
    logic         o_valid;
    logic         i_ready;
    logic [3:0]   o_slot_valid;
    logic [15:0]  o_class;
    logic [19:0]  o_rd;
    logic [19:0]  o_rs1;
    logic [19:0]  o_rs2;
    logic [127:0] o_imm;
    logic [127:0] o_pc;
    logic         o_redirect;
    logic [31:0]  o_redirect_pc;
`ifdef PREDEC_DEP_EN
    logic [15:0]  o_dep;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_predecode dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_bundle      (i_bundle),
        .i_flush       (i_flush),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_slot_valid  (o_slot_valid),
        .o_class       (o_class),
        .o_rd          (o_rd),
        .o_rs1         (o_rs1),
        .o_rs2         (o_rs2),
        .o_imm         (o_imm),
        .o_pc          (o_pc),
        .o_redirect    (o_redirect),
        .o_redirect_pc (o_redirect_pc)
`ifdef PREDEC_DEP_EN
        ,
        .o_dep         (o_dep)
`endif
    );

    typedef struct {
        logic [3:0][31:0] ins;
        logic [31:0]      pc0;
        logic [3:0]       sv;
        logic [15:0]      cls;
        logic [19:0]      rd;
        logic [19:0]      rs1;
        logic [19:0]      rs2;
        logic [127:0]     imm;
        logic             redir;
        logic [31:0]      rpc;
        logic [15:0]      dep;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_bundle(input logic [3:0][31:0] ins, input logic [31:0] pc0);
        for (int k = 0; k < 4; k++) begin
            i_bundle[64*k +: 64] = {pc0 + 32'(4*k), ins[k]};
        end
    endtask

    // One addi x1,x0,n in slot 0, NOP padding elsewhere.
    task automatic set_simple(input logic [31:0] pc0, input logic [11:0] n);
        logic [3:0][31:0] ins;
        ins = {NOP, NOP, NOP, {n, 20'h00093}};
        set_bundle(ins, pc0);
    endtask

    task automatic flush_cycle();
        i_flush = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        tick();
        i_flush = 1'b0;
    endtask

    initial begin
        logic [127:0] exp_pc;
        logic [3:0][31:0] jal_ins;

        rst      = 1'b0;
        i_valid  = 1'b0;
        i_flush  = 1'b0;
        i_ready  = 1'b0;
        i_bundle = '0;

        // addi x1,x0,5 + NOPs
        vecs[0] = '{ins: {NOP, NOP, NOP, 32'h0050_0093}, pc0: 32'h100, sv: 4'b0001,
                    cls: 16'h1111, rd: {5'd0, 5'd0, 5'd0, 5'd1}, rs1: '0,
                    rs2: {5'd0, 5'd0, 5'd0, 5'd5},
                    imm: {32'h0, 32'h0, 32'h0, 32'h5}, redir: 1'b0, rpc: 32'h0, dep: 16'h0};
        // lw x5,-4(x2); sw x6,8(x2); beq x1,x2,-8; lui x7,0x12345
        vecs[1] = '{ins: {32'h1234_53B7, 32'hFE20_8CE3, 32'h0061_2423, 32'hFFC1_2283},
                    pc0: 32'h1000, sv: 4'b1111, cls: 16'h7432,
                    rd: {5'd7, 5'd25, 5'd8, 5'd5}, rs1: {5'd8, 5'd1, 5'd2, 5'd2},
                    rs2: {5'd3, 5'd2, 5'd6, 5'd28},
                    imm: {32'h1234_5000, 32'hFFFF_FFF8, 32'h0000_0008, 32'hFFFF_FFFC},
                    redir: 1'b0, rpc: 32'h0, dep: 16'h0};
        // addi x1; jal x1,+8 @0x204; add x2,x1,x1 x2 (squashed)
        vecs[2] = '{ins: {32'h0010_8133, 32'h0010_8133, 32'h0080_00EF, 32'h0050_0093},
                    pc0: 32'h200, sv: 4'b0011, cls: 16'h0051,
                    rd: {5'd2, 5'd2, 5'd1, 5'd1}, rs1: {5'd1, 5'd1, 5'd0, 5'd0},
                    rs2: {5'd1, 5'd1, 5'd8, 5'd5},
                    imm: {32'h0, 32'h0, 32'h8, 32'h5}, redir: 1'b1, rpc: 32'h20C, dep: 16'h0};
        // addi x1; add x2,x1,x1; NOP; NOP
        vecs[3] = '{ins: {NOP, NOP, 32'h0010_8133, 32'h0050_0093}, pc0: 32'h300, sv: 4'b0011,
                    cls: 16'h1101, rd: {5'd0, 5'd0, 5'd2, 5'd1}, rs1: {5'd0, 5'd0, 5'd1, 5'd0},
                    rs2: {5'd0, 5'd0, 5'd1, 5'd5},
                    imm: {32'h0, 32'h0, 32'h0, 32'h5}, redir: 1'b0, rpc: 32'h0, dep: 16'h0010};
        // illegal; ecall; jalr x0,0(x1); auipc x3,0xFFFFF
        vecs[4] = '{ins: {32'hFFFF_F197, 32'h0000_8067, 32'h0000_0073, 32'hFFFF_FFFF},
                    pc0: 32'h8000_0000, sv: 4'b1111, cls: 16'h869F,
                    rd: {5'd3, 5'd0, 5'd0, 5'd31}, rs1: {5'd31, 5'd1, 5'd0, 5'd31},
                    rs2: {5'd31, 5'd0, 5'd0, 5'd31},
                    imm: {32'hFFFF_F000, 32'h0, 32'h0, 32'h0}, redir: 1'b0, rpc: 32'h0, dep: 16'h0};
        // jal x0,-16 @0x8 (wraps) followed by three more JALs
        vecs[5] = '{ins: {32'h0080_00EF, 32'h0080_00EF, 32'h0080_00EF, 32'hFF1F_F06F},
                    pc0: 32'h8, sv: 4'b0001, cls: 16'h5555,
                    rd: {5'd1, 5'd1, 5'd1, 5'd0}, rs1: {5'd0, 5'd0, 5'd0, 5'd31},
                    rs2: {5'd8, 5'd8, 5'd8, 5'd17},
                    imm: {32'h8, 32'h8, 32'h8, 32'hFFFF_FFF0},
                    redir: 1'b1, rpc: 32'hFFFF_FFF8, dep: 16'h0};

        // Reset values while held in reset
        tick();
        tick();
        chk("rst o_valid", 128'(o_valid), 128'd0);
        chk("rst o_ready", 128'(o_ready), 128'd1);
        chk("rst o_redirect", 128'(o_redirect), 128'd0);
        chk("rst o_redirect_pc", 128'(o_redirect_pc), 128'd0);
        chk("rst o_imm", o_imm, 128'd0);
        chk("rst o_pc", o_pc, 128'd0);
        chk("rst o_slot_valid", 128'(o_slot_valid), 128'd0);
        rst = 1'b1;
        tick();

        // Table: push one bundle into an empty FIFO, check head, hold, pop
        for (int v = 0; v < 6; v++) begin
            flush_cycle();
            set_bundle(vecs[v].ins, vecs[v].pc0);
            i_valid = 1'b1;
            tick();
            i_valid = 1'b0;
            for (int k = 0; k < 4; k++) exp_pc[32*k +: 32] = vecs[v].pc0 + 32'(4*k);
            chk($sformatf("v%0d o_valid", v), 128'(o_valid), 128'd1);
            chk($sformatf("v%0d slot_valid", v), 128'(o_slot_valid), 128'(vecs[v].sv));
            chk($sformatf("v%0d class", v), 128'(o_class), 128'(vecs[v].cls));
            chk($sformatf("v%0d rd", v), 128'(o_rd), 128'(vecs[v].rd));
            chk($sformatf("v%0d rs1", v), 128'(o_rs1), 128'(vecs[v].rs1));
            chk($sformatf("v%0d rs2", v), 128'(o_rs2), 128'(vecs[v].rs2));
            chk($sformatf("v%0d imm", v), o_imm, vecs[v].imm);
            chk($sformatf("v%0d pc", v), o_pc, exp_pc);
            chk($sformatf("v%0d redirect", v), 128'(o_redirect), 128'(vecs[v].redir));
            if (vecs[v].redir) begin
                chk($sformatf("v%0d redirect_pc", v), 128'(o_redirect_pc), 128'(vecs[v].rpc));
            end
`ifdef PREDEC_DEP_EN
            chk($sformatf("v%0d dep", v), 128'(o_dep), 128'(vecs[v].dep));
`endif
            tick();
            chk($sformatf("v%0d redirect pulse end", v), 128'(o_redirect), 128'd0);
            chk($sformatf("v%0d held o_valid", v), 128'(o_valid), 128'd1);
            i_ready = 1'b1;
            tick();
            i_ready = 1'b0;
            chk($sformatf("v%0d popped o_valid", v), 128'(o_valid), 128'd0);
            chk($sformatf("v%0d empty imm", v), o_imm, 128'd0);
        end

        // Backpressure: two entries fill the FIFO, third waits, order preserved
        flush_cycle();
        i_valid = 1'b1;
        set_simple(32'hA00, 12'd1);
        tick();
        chk("bp ready after 1", 128'(o_ready), 128'd1);
        chk("bp head B1 (1)", 128'(o_pc[31:0]), 128'h0A00);
        set_simple(32'hB00, 12'd2);
        tick();
        chk("bp ready after 2", 128'(o_ready), 128'd0);
        chk("bp head B1 (2)", 128'(o_pc[31:0]), 128'h0A00);
        set_simple(32'hC00, 12'd3);
        tick();
        chk("bp ready full", 128'(o_ready), 128'd0);
        chk("bp head B1 (3)", 128'(o_pc[31:0]), 128'h0A00);
        i_ready = 1'b1;
        tick();
        chk("bp head B2", 128'(o_pc[31:0]), 128'h0B00);
        chk("bp imm B2", 128'(o_imm[31:0]), 128'd2);
        chk("bp ready after pop", 128'(o_ready), 128'd1);
        tick();
        i_valid = 1'b0;
        chk("bp head B3", 128'(o_pc[31:0]), 128'h0C00);
        chk("bp imm B3", 128'(o_imm[31:0]), 128'd3);
        tick();
        i_ready = 1'b0;
        chk("bp drained", 128'(o_valid), 128'd0);

        // DROP: bundles after a JAL are discarded until flush, FIFO still drains
        jal_ins = {32'h0010_8133, 32'h0010_8133, 32'h0080_00EF, 32'h0050_0093};
        flush_cycle();
        set_bundle(jal_ins, 32'h200);
        i_valid = 1'b1;
        tick();
        chk("drop jal head", 128'(o_valid), 128'd1);
        set_simple(32'hD00, 12'd4);
        i_ready = 1'b1;
        tick();
        chk("drop discarded o_valid", 128'(o_valid), 128'd0);
        chk("drop o_ready", 128'(o_ready), 128'd1);
        tick();
        chk("drop still discarding", 128'(o_valid), 128'd0);
        i_valid = 1'b0;
        i_ready = 1'b0;
        flush_cycle();
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        chk("after flush accepted", 128'(o_valid), 128'd1);
        chk("after flush head", 128'(o_pc[31:0]), 128'h0D00);

        // All-NOP bundle is accepted but never enqueued
        flush_cycle();
        set_bundle({NOP, NOP, NOP, NOP}, 32'h400);
        i_valid = 1'b1;
        chk("allnop o_ready", 128'(o_ready), 128'd1);
        tick();
        i_valid = 1'b0;
        chk("allnop o_valid", 128'(o_valid), 128'd0);
        chk("allnop redirect", 128'(o_redirect), 128'd0);

        // Flush with a same-cycle input while the FIFO is full
        flush_cycle();
        i_valid = 1'b1;
        set_simple(32'hE00, 12'd5);
        tick();
        set_simple(32'hE40, 12'd6);
        tick();
        chk("flush pre full", 128'(o_ready), 128'd0);
        set_simple(32'hE80, 12'd7);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("flush o_valid", 128'(o_valid), 128'd0);
        chk("flush o_ready", 128'(o_ready), 128'd1);
        chk("flush payload", o_pc, 128'd0);
        tick();
        chk("flush input dropped", 128'(o_valid), 128'd0);

        // Flush alongside a JAL bundle: no redirect, nothing enqueued
        set_bundle(jal_ins, 32'h200);
        i_valid = 1'b1;
        i_flush = 1'b1;
        tick();
        i_valid = 1'b0;
        i_flush = 1'b0;
        chk("flush jal redirect", 128'(o_redirect), 128'd0);
        chk("flush jal o_valid", 128'(o_valid), 128'd0);

        // Asynchronous reset mid-operation
        set_bundle(jal_ins, 32'h200);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        chk("pre-reset redirect", 128'(o_redirect), 128'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst o_redirect", 128'(o_redirect), 128'd0);
        chk("async rst o_redirect_pc", 128'(o_redirect_pc), 128'd0);
        chk("async rst o_valid", 128'(o_valid), 128'd0);
        chk("async rst slot_valid", 128'(o_slot_valid), 128'd0);
        #2;
        rst = 1'b1;
        tick();
        chk("post-reset o_ready", 128'(o_ready), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_predecode.md
Name: instr_predecode

Overview:
- Sits directly downstream of the instruction queue.
- Accepts one 4-slot issue bundle per transfer. Each slot is a 64-bit {PC, instruction} entry.
- Predecodes RV32I fields per slot, marks NOP padding slots invalid, and detects JAL for an early front-end redirect.
- Holds up to 2 predecoded bundles in a FIFO for the decode/rename stage.

Parameters:
- ISSUEWIDTH, 4, slots per bundle.
- DEPTH, 2, predecoded-bundle FIFO entries.
- NOP_WORD, 32'h00000013, padding encoding inserted by the queue.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_valid  in  1  upstream bundle valid.
- o_ready  out  1  block can accept a bundle this cycle.
- i_bundle  in  256  slot k = bits [64k+63:64k]; [64k+63:64k+32] = PC, [64k+31:64k] = instruction.
- i_flush  in  1  front-end flush; clears all state.
- o_valid  out  1  head bundle valid.
- i_ready  in  1  downstream accepts head bundle.
- o_slot_valid  out  4  per-slot valid.
- o_class  out  16  4 bits per slot: 0 ALU, 1 ALUI, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM, 15 ILLEGAL.
- o_rd, o_rs1, o_rs2  out  20 each  5 bits per slot.
- o_imm  out  128  32-bit sign-extended immediate per slot; 0 for R-type.
- o_pc  out  128  32-bit PC per slot.
- o_redirect  out  1  one-cycle redirect pulse.
- o_redirect_pc  out  32  redirect target.

Behaviour:
- Reset (rst low, asynchronous): FIFO empty, state RUN. o_valid=0, o_redirect=0, o_redirect_pc=0, all payload outputs 0.
- Input handshake:
  - Transfer occurs when i_valid & o_ready.
  - o_ready = (count < DEPTH) in RUN; o_ready = 1 in DROP.
- Output handshake:
  - Pop occurs when o_valid & i_ready.
  - Payload outputs are driven from the FIFO head; they are 0 when empty.
- Latency: a bundle accepted in cycle N is visible at the output in cycle N+1 when the FIFO was empty.
- Simultaneous push and pop when full: not allowed, because o_ready is low when full (no bypass).
- Per-slot predecode (combinational on input, registered into the FIFO):
  - slot valid = instruction != NOP_WORD.
  - Class from opcode [6:0]. Unknown opcode -> ILLEGAL, slot still valid.
  - rd/rs1/rs2 taken from fixed bit positions.
  - Immediate formatted per I/S/B/U/J format.
- All-NOP bundle (slot_valid==0): accepted but not enqueued.
- JAL redirect:
  - Find the lowest valid slot k with class JAL.
  - Slots > k are cleared in slot_valid.
  - o_redirect pulses 1 in the cycle after acceptance, with o_redirect_pc = pc_k + imm_k (mod 2^32).
  - State goes RUN -> DROP.
  - If several JALs are in one bundle, only the lowest slot counts.
- DROP state:
  - Input bundles are accepted and discarded.
  - FIFO still drains normally.
  - i_flush returns the state to RUN.
- i_flush:
  - Synchronous; empties the FIFO and discards any same-cycle input transfer (flush wins).
  - Suppresses any pending o_redirect.
  - o_valid=0 next cycle; state RUN.
- Reset asserted mid-operation: immediate return to reset values.

Optional Feature:
- Macro PREDEC_DEP_EN. When defined, adds output port o_dep [15:0].
  - Bit 4j+i (i<j) = 1 when slot j reads rs1 or rs2 equal to a nonzero rd of valid older slot i that writes rd.
  - Slot i writes rd for classes ALU, ALUI, LOAD, JAL, JALR, LUI, AUIPC.
  - All other bits = 0. Value is stored in the FIFO with the bundle.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package predecode_pkg:
  - class encodings, opcode constants, NOP_WORD;
  - slot field offsets (PC high, instruction low);
  - predecoded-slot struct {valid, class, rd, rs1, rs2, imm, pc}.
- Sub-module slot_predecode: purely combinational decoder for one slot, instantiated ISSUEWIDTH times.
- FIFO, redirect logic and state machine stay in the top module.

Test Plan:
- Reset then push bundle addi x1,x0,5 (0x00500093) @PC 0x100 plus 3x NOP -> next cycle o_valid=1, o_slot_valid=4'b0001, class ALUI, rd=1, imm=5.
- Hold i_ready=0 and push 3 bundles -> o_ready drops after 2 transfers; third bundle is held; pops return bundles in order.
- Bundle with slot1 = JAL x1,+8 (0x008000EF) @PC 0x204, slot2/slot3 = ALU -> o_slot_valid=4'b0011; o_redirect=1 for one cycle with target 0x20C; next bundle discarded until i_flush.
- All-NOP bundle -> accepted, o_valid stays 0.
- i_flush together with i_valid while FIFO holds 2 bundles -> FIFO empty next cycle, input dropped, o_ready=1.
- With PREDEC_DEP_EN: slot0 addi x1 (0x00500093), slot1 add x2,x1,x1 (0x00108133) -> o_dep bit 4 = 1, all other bits 0.
